// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the core-to-bus data memory bridge.
package mem_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADDR  = 2'b01,
        RDATA = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Access size encodings taken from funct3[1:0]; 2'b11 is illegal
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage : mem_bridge_pkg

// File: rtl/data_mem_bridge_lane_steer.sv
// Combinational byte-lane steering: strobes, replicated store data and
// alignment check for one access, derived from its size and low address bits.
module lane_steer
    import mem_bridge_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    // Replicate the store operand across lanes so the strobes alone pick the bytes
    always_comb begin
        wstrb_o    = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = 1'b1;
        case (size_i)
            SZ_B: begin
                wstrb_o    = 4'b0001 << addr_lo_i;
                wdata_o    = {4{wdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            SZ_H: begin
                wstrb_o    = 4'b0011 << addr_lo_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            SZ_W: begin
                wstrb_o    = 4'b1111;
                wdata_o    = wdata_i;
                misalign_o = |addr_lo_i;
            end
            default: begin
                wstrb_o    = 4'b0000;
                wdata_o    = wdata_i;
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule : lane_steer

// File: rtl/data_mem_bridge.sv
// Multi-cycle bridge from the single-cycle core's data port to a valid/ready
// memory bus. One access per core request; the core is stalled until the
// one-cycle rsp_valid pulse, and load bytes come back right-justified.
module data_mem_bridge
    import mem_bridge_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_e      state_q;
    logic        we_q;
    logic [1:0]  addr_lo_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        misalign_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] mem_wdata_q;

    logic [3:0]  steer_wstrb;
    logic [31:0] steer_wdata;
    logic        steer_misalign;

    // Signedness bit of funct3 is handled by the core's load extension logic
    logic        unused_funct3;
    assign unused_funct3 = req_funct3[2];

    lane_steer u_lane_steer (
        .size_i     (req_funct3[1:0]),
        .addr_lo_i  (req_addr[1:0]),
        .wdata_i    (req_wdata),
        .wstrb_o    (steer_wstrb),
        .wdata_o    (steer_wdata),
        .misalign_o (steer_misalign)
    );

    // Core stays frozen for the whole access and is released in DONE, where it retires
    assign stall = req_valid && (state_q != DONE);

    // Bridge FSM with all bus and response outputs registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_lo_q   <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            misalign_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_lo_q <= req_addr[1:0];
                        if (steer_misalign) begin
                            // Bad alignment or size never reaches the bus
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            misalign_q  <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ADDR;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wstrb_q <= req_we ? steer_wstrb : 4'b0000;
                            mem_wdata_q <= req_we ? steer_wdata : 32'h0;
                        end
                    end
                end
                ADDR: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if (we_q) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            misalign_q  <= 1'b0;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (mem_rvalid) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        misalign_q  <= 1'b0;
                        rsp_rdata_q <= mem_rdata >> {addr_lo_q, 3'b000};
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    misalign_q  <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign misalign  = misalign_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule : data_mem_bridge

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: expected results are queued when a
// request is issued and popped once the bridge completes the access.
module tb_data_mem_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc_g = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          nbus;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          stall;
    } xact_t;

    xact_t exp_q[$];

    data_mem_bridge dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .misalign   (misalign),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc_g <= cyc_g + 1;

    // Reference model of the lane rules
    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic xact_t mk(input logic we, input logic [31:0] addr, input logic [3:0] ws,
                                 input logic [31:0] wd, input int nbus, input logic [31:0] rd,
                                 input logic mis, input int lat);
        xact_t x;
        x.we = we; x.addr = addr; x.wstrb = ws; x.wdata = wd; x.nbus = nbus;
        x.rdata = rd; x.mis = mis; x.lat = lat; x.stall = lat;
        return x;
    endfunction

    // Core + bus driver: issues one request, plays the bus, records what the DUT did
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int rwait, input int vwait,
                           input logic [31:0] rd, input bit stray,
                           output xact_t o, output int mv_cyc, output int rsp_cyc, output bit tmo);
        int  t = 0;
        int  rc = 0;
        int  vc = 0;
        bit  rphase = 0;
        bit  done = 0;
        bit  rdy;
        o = mk(1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1'b0, -1);
        o.stall = 0;
        mv_cyc = -1;
        rsp_cyc = -1;
        tmo = 0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        while (!done) begin
            mem_rvalid = 1'b0;
            rdy = mem_valid && (rc >= rwait);
            mem_ready = rdy;
            if (mem_valid && !rdy) begin
                rc++;
                if (stray) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hFFFF_FFFF;
                end
            end
            if (rphase) begin
                if (vc >= vwait) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd;
                    rphase     = 0;
                end else begin
                    vc++;
                end
            end
            #1;
            if (stall) o.stall++;
            if (mem_valid && mv_cyc < 0) mv_cyc = cyc_g;
            if (mem_valid && mem_ready) begin
                o.nbus++;
                o.we = mem_we; o.addr = mem_addr; o.wstrb = mem_wstrb; o.wdata = mem_wdata;
                if (!mem_we) rphase = 1;
            end
            if (rsp_valid) begin
                o.rdata = rsp_rdata; o.mis = misalign; o.lat = t; rsp_cyc = cyc_g;
                done = 1;
            end else if (t >= 60) begin
                tmo = 1;
                done = 1;
            end else begin
                @(posedge clock); #1;
                t++;
            end
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_cnt++;
        if ({mem_valid, rsp_valid, misalign, stall} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_ctl: got %b expected 0000", {mem_valid, rsp_valid, misalign, stall});
        end
        chk_cnt++;
        if ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== 69'h0) begin
            err_cnt++;
            $display("FAIL reset_bus: got %h expected 0", {mem_we, mem_addr, mem_wstrb, mem_wdata});
        end
        chk_cnt++;
        if (rsp_rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_rdata: got %h expected 0", rsp_rdata);
        end
        @(negedge clock);
        reset = 1'b1;
        $display("reset released, idle outputs checked");
    endtask

    task automatic test_store_byte;
        xact_t o, e;
        int mv, rc;
        bit tmo;
        exp_q.push_back(mk(1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1, 32'h0, 1'b0, 2));
        run_req(1'b1, 3'b000, 32'h103, 32'h0000_00AB, 0, 0, 32'h0, 0, o, mv, rc, tmo);
        e = exp_q.pop_front();
        $display("store byte 0x103: addr=%h strb=%b wdata=%h lat=%0d", o.addr, o.wstrb, o.wdata, o.lat);
        chk_cnt++;
        if (tmo) begin err_cnt++; $display("FAIL store_byte_timeout: no rsp_valid within budget"); end
        chk_cnt++;
        if ({o.we, o.addr, o.wstrb, o.wdata} !== {e.we, e.addr, e.wstrb, e.wdata}) begin
            err_cnt++;
            $display("FAIL store_byte_bus: got %b/%h/%b/%h expected %b/%h/%b/%h",
                     o.we, o.addr, o.wstrb, o.wdata, e.we, e.addr, e.wstrb, e.wdata);
        end
        chk_cnt++;
        if (o.nbus !== e.nbus) begin err_cnt++; $display("FAIL store_byte_nbus: got %0d expected %0d", o.nbus, e.nbus); end
        chk_cnt++;
        if (o.lat !== e.lat || o.stall !== e.stall) begin
            err_cnt++;
            $display("FAIL store_byte_timing: got lat=%0d stall=%0d expected lat=%0d stall=%0d", o.lat, o.stall, e.lat, e.stall);
        end
        chk_cnt++;
        if ({o.rdata, o.mis} !== {e.rdata, e.mis}) begin
            err_cnt++;
            $display("FAIL store_byte_rsp: got %h/%b expected %h/%b", o.rdata, o.mis, e.rdata, e.mis);
        end
    endtask

    task automatic test_load_half_latency;
        xact_t o, e;
        int mv, rc;
        bit tmo;
        // request, 2 ready-low cycles, accept, 3 cycles to rvalid, done
        exp_q.push_back(mk(1'b0, 32'h200, 4'b0000, 32'h0, 1, 32'h0000_8765, 1'b0, 7));
        run_req(1'b0, 3'b101, 32'h202, 32'h0, 2, 2, 32'h8765_4321, 0, o, mv, rc, tmo);
        e = exp_q.pop_front();
        $display("load half 0x202: rdata=%h mis=%b lat=%0d", o.rdata, o.mis, o.lat);
        chk_cnt++;
        if (tmo) begin err_cnt++; $display("FAIL load_half_timeout: no rsp_valid within budget"); end
        chk_cnt++;
        if ({o.we, o.addr, o.wstrb} !== {e.we, e.addr, e.wstrb} || o.nbus !== e.nbus) begin
            err_cnt++;
            $display("FAIL load_half_bus: got %b/%h/%b n=%0d expected %b/%h/%b n=%0d",
                     o.we, o.addr, o.wstrb, o.nbus, e.we, e.addr, e.wstrb, e.nbus);
        end
        chk_cnt++;
        if ({o.rdata, o.mis} !== {e.rdata, e.mis}) begin
            err_cnt++;
            $display("FAIL load_half_rsp: got %h/%b expected %h/%b", o.rdata, o.mis, e.rdata, e.mis);
        end
        chk_cnt++;
        if (o.lat !== e.lat || o.stall !== e.stall) begin
            err_cnt++;
            $display("FAIL load_half_timing: got lat=%0d stall=%0d expected lat=%0d stall=%0d", o.lat, o.stall, e.lat, e.stall);
        end
    endtask

    task automatic test_misaligned;
        logic [2:0]  f3_t[3]   = '{3'b010, 3'b011, 3'b001};
        logic [31:0] addr_t[3] = '{32'h301, 32'h0, 32'h205};
        xact_t o, e;
        int mv, rc;
        bit tmo;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1'b1, 1));
            run_req(i[0], f3_t[i], addr_t[i], 32'h5555_5555, 0, 0, 32'h0, 0, o, mv, rc, tmo);
            e = exp_q.pop_front();
            $display("misaligned f3=%b addr=%h: mis=%b lat=%0d mv_cyc=%0d", f3_t[i], addr_t[i], o.mis, o.lat, mv);
            chk_cnt++;
            if (tmo) begin err_cnt++; $display("FAIL misalign_timeout[%0d]: no rsp_valid within budget", i); end
            chk_cnt++;
            if (mv !== -1 || o.nbus !== e.nbus) begin
                err_cnt++;
                $display("FAIL misalign_nobus[%0d]: got mem_valid at cyc %0d n=%0d expected none", i, mv, o.nbus);
            end
            chk_cnt++;
            if ({o.rdata, o.mis} !== {e.rdata, e.mis}) begin
                err_cnt++;
                $display("FAIL misalign_rsp[%0d]: got %h/%b expected %h/%b", i, o.rdata, o.mis, e.rdata, e.mis);
            end
            chk_cnt++;
            if (o.lat !== e.lat || o.stall !== e.stall) begin
                err_cnt++;
                $display("FAIL misalign_timing[%0d]: got lat=%0d stall=%0d expected %0d", i, o.lat, o.stall, e.lat);
            end
        end
    endtask

    task automatic test_lane_patterns;
        logic        we_t[5]    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3_t[5]    = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b010};
        logic [31:0] addr_t[5]  = '{32'h12, 32'h20, 32'h31, 32'h33, 32'h40};
        logic [31:0] wd_t[5]    = '{32'h1234_CAFE, 32'h0102_0304, 32'h0, 32'h0, 32'h0};
        logic [31:0] rd_t[5]    = '{32'h0, 32'h0, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 32'h55AA_33CC};
        int          rw_t[5]    = '{1, 0, 0, 3, 1};
        xact_t o, e;
        int mv, rc, lat;
        bit tmo;
        for (int i = 0; i < 5; i++) begin
            lat = 2 + rw_t[i] + (we_t[i] ? 0 : 1 + i);
            exp_q.push_back(mk(we_t[i], {addr_t[i][31:2], 2'b00},
                               we_t[i] ? m_strb(f3_t[i][1:0], addr_t[i][1:0]) : 4'b0000,
                               m_wdata(f3_t[i][1:0], wd_t[i]), 1,
                               we_t[i] ? 32'h0 : rd_t[i] >> (8 * addr_t[i][1:0]), 1'b0, lat));
            run_req(we_t[i], f3_t[i], addr_t[i], wd_t[i], rw_t[i], i, rd_t[i], 0, o, mv, rc, tmo);
            e = exp_q.pop_front();
            $display("lanes[%0d] we=%b addr=%h: strb=%b wdata=%h rdata=%h lat=%0d",
                     i, we_t[i], addr_t[i], o.wstrb, o.wdata, o.rdata, o.lat);
            chk_cnt++;
            if (tmo || o.lat !== e.lat) begin
                err_cnt++;
                $display("FAIL lanes_timing[%0d]: got lat=%0d timeout=%b expected lat=%0d", i, o.lat, tmo, e.lat);
            end
            chk_cnt++;
            if ({o.we, o.addr, o.wstrb} !== {e.we, e.addr, e.wstrb}) begin
                err_cnt++;
                $display("FAIL lanes_bus[%0d]: got %b/%h/%b expected %b/%h/%b", i, o.we, o.addr, o.wstrb, e.we, e.addr, e.wstrb);
            end
            if (we_t[i]) begin
                chk_cnt++;
                if (o.wdata !== e.wdata) begin
                    err_cnt++;
                    $display("FAIL lanes_wdata[%0d]: got %h expected %h", i, o.wdata, e.wdata);
                end
            end
            chk_cnt++;
            if ({o.rdata, o.mis} !== {e.rdata, e.mis}) begin
                err_cnt++;
                $display("FAIL lanes_rsp[%0d]: got %h/%b expected %h/%b", i, o.rdata, o.mis, e.rdata, e.mis);
            end
        end
    endtask

    task automatic test_back_to_back;
        xact_t o1, o2, e1, e2;
        int mv1, rc1, mv2, rc2;
        bit tmo1, tmo2;
        exp_q.push_back(mk(1'b1, 32'h400, 4'b1111, 32'h1122_3344, 1, 32'h0, 1'b0, 2));
        exp_q.push_back(mk(1'b0, 32'h400, 4'b0000, 32'h0, 1, 32'h1122_3344, 1'b0, 3));
        run_req(1'b1, 3'b010, 32'h400, 32'h1122_3344, 0, 0, 32'h0, 0, o1, mv1, rc1, tmo1);
        run_req(1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h1122_3344, 0, o2, mv2, rc2, tmo2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        $display("back-to-back: rsp1 cyc %0d, mem_valid2 cyc %0d, rdata2=%h", rc1, mv2, o2.rdata);
        chk_cnt++;
        if (tmo1 || tmo2) begin err_cnt++; $display("FAIL b2b_timeout: got %b/%b expected 0/0", tmo1, tmo2); end
        // one IDLE cycle accepts the next request, bus request follows it
        chk_cnt++;
        if (mv2 - rc1 !== 2) begin
            err_cnt++;
            $display("FAIL b2b_gap: got mem_valid %0d cycles after rsp_valid expected 2", mv2 - rc1);
        end
        chk_cnt++;
        if ({o1.we, o1.addr, o1.wstrb, o1.wdata} !== {e1.we, e1.addr, e1.wstrb, e1.wdata}) begin
            err_cnt++;
            $display("FAIL b2b_store_bus: got %b/%h/%b/%h expected %b/%h/%b/%h",
                     o1.we, o1.addr, o1.wstrb, o1.wdata, e1.we, e1.addr, e1.wstrb, e1.wdata);
        end
        chk_cnt++;
        if ({o2.we, o2.addr, o2.wstrb} !== {e2.we, e2.addr, e2.wstrb} || o2.lat !== e2.lat) begin
            err_cnt++;
            $display("FAIL b2b_load_bus: got %b/%h/%b lat=%0d expected %b/%h/%b lat=%0d",
                     o2.we, o2.addr, o2.wstrb, o2.lat, e2.we, e2.addr, e2.wstrb, e2.lat);
        end
        chk_cnt++;
        if ({o2.rdata, o2.mis} !== {e2.rdata, e2.mis}) begin
            err_cnt++;
            $display("FAIL b2b_load_rsp: got %h/%b expected %h/%b", o2.rdata, o2.mis, e2.rdata, e2.mis);
        end
    endtask

    task automatic test_reset_mid_read;
        bit seen_rsp = 0;
        bit seen_mv = 0;
        xact_t o, e;
        int mv, rc;
        bit tmo;
        // Abort while the bus request is pending
        @(posedge clock); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500; mem_ready = 1'b0;
        @(posedge clock); #1;
        chk_cnt++;
        if (mem_valid !== 1'b1) begin err_cnt++; $display("FAIL abort_addr_pre: got mem_valid=%b expected 1", mem_valid); end
        reset = 1'b0; req_valid = 1'b0;
        #1;
        chk_cnt++;
        if (mem_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_addr_drop: got mem_valid=%b expected 0", mem_valid); end
        @(posedge clock); #1;
        reset = 1'b1;
        // Abort while waiting for read data
        @(posedge clock); #1;
        req_valid = 1'b1; req_addr = 32'h504;
        @(posedge clock); #1;
        mem_ready = 1'b1;
        @(posedge clock); #1;
        mem_ready = 1'b0;
        reset = 1'b0; req_valid = 1'b0;
        #1;
        chk_cnt++;
        if ({mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, rsp_valid, rsp_rdata, misalign} !== 104'h0) begin
            err_cnt++;
            $display("FAIL abort_rdata_zero: got mem_valid=%b addr=%h rsp_valid=%b rdata=%h expected all 0",
                     mem_valid, mem_addr, rsp_valid, rsp_rdata);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            mem_rvalid = (n == 1);
            mem_rdata  = 32'hCAFE_F00D;
            #1;
            if (rsp_valid) seen_rsp = 1;
            if (mem_valid) seen_mv = 1;
            @(posedge clock); #1;
        end
        mem_rvalid = 1'b0;
        $display("reset mid-read: late rvalid gave rsp_valid=%b mem_valid=%b", seen_rsp, seen_mv);
        chk_cnt++;
        if (seen_rsp || seen_mv) begin
            err_cnt++;
            $display("FAIL abort_late_rvalid: got rsp_valid=%b mem_valid=%b expected 0/0", seen_rsp, seen_mv);
        end
        // A fresh misaligned request finishing in one cycle shows the FSM is idle
        exp_q.push_back(mk(1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1'b1, 1));
        run_req(1'b0, 3'b011, 32'h0, 32'h0, 0, 0, 32'h0, 0, o, mv, rc, tmo);
        e = exp_q.pop_front();
        chk_cnt++;
        if (tmo || o.lat !== e.lat || o.mis !== e.mis) begin
            err_cnt++;
            $display("FAIL abort_idle_after: got lat=%0d mis=%b expected lat=%0d mis=%b", o.lat, o.mis, e.lat, e.mis);
        end
    endtask

    task automatic test_stray_rvalid;
        bit bad = 0;
        xact_t o, e;
        int mv, rc;
        bit tmo;
        req_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clock); #1;
            mem_rvalid = (n < 3);
            mem_rdata  = 32'h1234_5678;
            #1;
            if (rsp_valid || mem_valid) bad = 1;
        end
        mem_rvalid = 1'b0;
        $display("stray rvalid in IDLE: disturbance=%b", bad);
        chk_cnt++;
        if (bad) begin err_cnt++; $display("FAIL stray_idle: got rsp/mem activity expected none"); end
        // rvalid asserted during ADDR wait cycles must not complete the load
        exp_q.push_back(mk(1'b0, 32'h600, 4'b0000, 32'h0, 1, 32'h1357_9BDF, 1'b0, 5));
        run_req(1'b0, 3'b010, 32'h600, 32'h0, 2, 0, 32'h1357_9BDF, 1, o, mv, rc, tmo);
        e = exp_q.pop_front();
        $display("stray rvalid in ADDR: rdata=%h lat=%0d", o.rdata, o.lat);
        chk_cnt++;
        if (tmo || o.lat !== e.lat) begin
            err_cnt++;
            $display("FAIL stray_addr_timing: got lat=%0d timeout=%b expected lat=%0d", o.lat, tmo, e.lat);
        end
        chk_cnt++;
        if ({o.rdata, o.mis} !== {e.rdata, e.mis} || o.nbus !== e.nbus) begin
            err_cnt++;
            $display("FAIL stray_addr_rsp: got %h/%b n=%0d expected %h/%b n=%0d", o.rdata, o.mis, o.nbus, e.rdata, e.mis, e.nbus);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half_latency();
        test_misaligned();
        test_lane_patterns();
        test_back_to_back();
        test_reset_mid_read();
        test_stray_rvalid();
        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_data_mem_bridge
